// File: rtl/oled_pkg.sv
// Shared constants for the 96x64 OLED display path and the board-clock divider presets.
// Presets are terminal counts for a 100 MHz source: f_out = 100 MHz / (2*(count+1)).
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;

  localparam int CNT_6P25M   = 7;
  localparam int CNT_1K      = 49_999;
  localparam int CNT_200HZ   = 249_999;

endpackage

// File: rtl/flexible_clock.sv
// Programmable divider: out_clk toggles whenever the count reaches count_in.
// out_tick marks the cycle in which out_clk has just gone high.
module flexible_clock #(
  parameter int CNT_W = 32
) (
  input  logic             basys_clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  output logic             out_clk,
  output logic             out_tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  // >= rather than == so that lowering count_in below cnt wraps at once.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (cnt_q >= count_in) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = ~clk_q;
    end
  end

  always_ff @(posedge basys_clk) begin
    if (reset) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign out_clk  = clk_q;
  assign out_tick = tick_q;

endmodule

// File: rtl/idx_to_coord.sv
// Combinational row-major index to (x, y): long division by the constant WIDTH,
// one compare/subtract stage per index bit, exact for every input value.
module idx_to_coord
  import oled_pkg::*;
#(
  parameter int IDX_W  = 13,
  parameter int WIDTH  = OLED_WIDTH,
  parameter int HEIGHT = OLED_HEIGHT
) (
  input  logic [IDX_W-1:0] pix_index,
  output logic [IDX_W-1:0] x,
  output logic [IDX_W-1:0] y,
  output logic             in_range
);

  localparam logic [IDX_W:0] W_C   = (IDX_W+1)'(WIDTH);
  localparam logic [31:0]    PIX_C = 32'(WIDTH * HEIGHT);

  logic [IDX_W:0]   rem;
  logic [IDX_W-1:0] quo;

  // Remainder stays below WIDTH between stages, so its top bit is always free.
  always_comb begin
    rem = '0;
    quo = '0;
    for (int i = IDX_W - 1; i >= 0; i--) begin
      rem = {rem[IDX_W-1:0], pix_index[i]};
      if (rem >= W_C) begin
        rem    = rem - W_C;
        quo[i] = 1'b1;
      end
    end
  end

  assign x        = rem[IDX_W-1:0];
  assign y        = quo;
  assign in_range = (32'(pix_index) < PIX_C);

endmodule

// File: rtl/flex_clock_coord.sv
// Display-timing helper: clock divider plus pixel-index-to-coordinate converter.
// Divider outputs are registered; coordinates are combinational from pix_index.
module flex_clock_coord
  import oled_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int IDX_W  = 13,
  parameter int WIDTH  = OLED_WIDTH,
  parameter int HEIGHT = OLED_HEIGHT
) (
  input  logic             basys_clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] count_in,
  output logic             out_clk,
  output logic             out_tick,
  input  logic [IDX_W-1:0] pix_index,
  output logic [IDX_W-1:0] x,
  output logic [IDX_W-1:0] y,
  output logic             in_range
);

  flexible_clock #(
    .CNT_W (CNT_W)
  ) u_div (
    .basys_clk (basys_clk),
    .reset     (reset),
    .count_in  (count_in),
    .out_clk   (out_clk),
    .out_tick  (out_tick)
  );

  idx_to_coord #(
    .IDX_W  (IDX_W),
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_coord (
    .pix_index (pix_index),
    .x         (x),
    .y         (y),
    .in_range  (in_range)
  );

endmodule

// File: tb/tb_flex_clock_coord.sv
// Bench for flex_clock_coord: edge-time scoreboard for the divider, index sweep for the converter.
module tb_flex_clock_coord;
  import oled_pkg::*;

  logic        basys_clk = 1'b0;
  logic        reset     = 1'b1;
  logic [31:0] count_in  = 32'(CNT_6P25M);
  logic        out_clk;
  logic        out_tick;
  logic [12:0] pix_index = '0;
  logic [12:0] x, y;
  logic        in_range;

  int checks = 0;
  int errors = 0;

  flex_clock_coord dut (
    .basys_clk (basys_clk),
    .reset     (reset),
    .count_in  (count_in),
    .out_clk   (out_clk),
    .out_tick  (out_tick),
    .pix_index (pix_index),
    .x         (x),
    .y         (y),
    .in_range  (in_range)
  );

  always #5 basys_clk = ~basys_clk;

  // Edge counter and out_clk edge monitor (sampled on the falling edge).
  int cyc = 0;
  always @(posedge basys_clk) cyc <= cyc + 1;

  int   rise_q[$];
  int   fall_q[$];
  int   exp_q[$];
  int   tick_cnt = 0;
  int   tick_bad = 0;
  logic prev_clk = 1'b0;
  int   rst_cyc  = 0;

  always @(negedge basys_clk) begin
    if (out_clk === 1'b1 && prev_clk === 1'b0) rise_q.push_back(cyc);
    if (out_clk === 1'b0 && prev_clk === 1'b1) fall_q.push_back(cyc);
    if (out_tick !== (out_clk === 1'b1 && prev_clk === 1'b0)) tick_bad++;
    if (out_tick === 1'b1) tick_cnt++;
    prev_clk = out_clk;
  end

  task automatic clear_mon();
    rise_q.delete();
    fall_q.delete();
    exp_q.delete();
    tick_cnt = 0;
    tick_bad = 0;
  endtask

  task automatic do_reset(input int ci);
    count_in = 32'(ci);
    reset    = 1'b1;
    repeat (2) @(posedge basys_clk);
    #1 reset = 1'b0;
    rst_cyc = cyc;
    clear_mon();
  endtask

  task automatic wait_rises(input int n, input int budget, output bit timed_out);
    int b = 0;
    while (rise_q.size() < n && b < budget) begin
      @(negedge basys_clk);
      #1;
      b++;
    end
    timed_out = (rise_q.size() < n);
  endtask

  task automatic test_reset();
    count_in = 32'd0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge basys_clk);
      #1;
      checks++;
      if (out_clk !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_clk got %b want 0", out_clk);
      end
      checks++;
      if (out_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_tick got %b want 0", out_tick);
      end
    end
  endtask

  task automatic test_div(input int ci, input int nrise);
    bit to;
    int exp;
    int got;
    int half = ci + 1;
    do_reset(ci);
    for (int k = 0; k < nrise; k++) exp_q.push_back(rst_cyc + half + 2 * half * k);
    wait_rises(nrise, 2 * half * (nrise + 1) + 10, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL div%0d_timeout got %0d rises want %0d", ci, rise_q.size(), nrise);
    end else begin
      for (int k = 0; k < nrise; k++) begin
        exp = exp_q.pop_front();
        got = rise_q[k];
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL div%0d_rise%0d got cycle %0d want %0d", ci, k, got - rst_cyc, exp - rst_cyc);
        end
      end
      for (int k = 0; k < nrise - 1; k++) begin
        checks++;
        if (k >= fall_q.size() || fall_q[k] !== rst_cyc + 2 * half * (k + 1)) begin
          errors++;
          $display("FAIL div%0d_fall%0d got cycle %0d want %0d", ci, k,
                   (k < fall_q.size()) ? fall_q[k] - rst_cyc : -1, 2 * half * (k + 1));
        end
      end
      checks++;
      if (tick_cnt !== rise_q.size()) begin
        errors++;
        $display("FAIL div%0d_tick_count got %0d want %0d", ci, tick_cnt, rise_q.size());
      end
      checks++;
      if (tick_bad !== 0) begin
        errors++;
        $display("FAIL div%0d_tick_align got %0d misaligned want 0", ci, tick_bad);
      end
    end
  endtask

  task automatic test_count_switch();
    bit to;
    int exp;
    do_reset(100);
    repeat (80) @(posedge basys_clk);
    #1 count_in = 32'd10;
    for (int k = 0; k < 4; k++) exp_q.push_back(rst_cyc + 81 + 22 * k);
    wait_rises(4, 200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL switch_timeout got %0d rises want 4", rise_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp = exp_q.pop_front();
        checks++;
        if (rise_q[k] !== exp) begin
          errors++;
          $display("FAIL switch_rise%0d got cycle %0d want %0d", k, rise_q[k] - rst_cyc, exp - rst_cyc);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int r2;
    do_reset(7);
    wait_rises(1, 40, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL midrst_first_rise got %0d rises want 1", rise_q.size());
    end
    while (cyc < rst_cyc + 11) @(posedge basys_clk);
    #1 reset = 1'b1;
    @(posedge basys_clk);
    #1 reset = 1'b0;
    r2 = cyc;
    checks++;
    if (out_clk !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clk_low got %b want 0", out_clk);
    end
    clear_mon();
    exp_q.push_back(r2 + 8);
    wait_rises(1, 40, to);
    checks++;
    if (to || rise_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL midrst_next_rise got cycle %0d want %0d",
               to ? -1 : rise_q[0] - r2, exp_q[0] - r2);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_coord_sweep();
    logic [26:0] exp;
    logic [26:0] got;
    int          shown = 0;
    for (int i = 0; i < 8192; i++) begin
      pix_index = 13'(i);
      exp_q.push_back({13'(i % 96), 13'(i / 96), 1'(i < 6144)});
      #1;
      exp = 27'(exp_q.pop_front());
      got = {x, y, in_range};
      checks++;
      if (got !== exp) begin
        errors++;
        if (shown < 10) begin
          shown++;
          $display("FAIL sweep_idx%0d got x=%0d y=%0d r=%b want x=%0d y=%0d r=%b",
                   i, x, y, in_range, exp[26:14], exp[13:1], exp[0]);
        end
      end
    end
  endtask

  task automatic test_coord_corners();
    int idx[6] = '{0, 95, 96, 6143, 6144, 8191};
    int ex[6]  = '{0, 95, 0, 95, 0, 31};
    int ey[6]  = '{0, 0, 1, 63, 64, 85};
    bit er[6]  = '{1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      pix_index = 13'(idx[i]);
      #1;
      checks++;
      if (x !== 13'(ex[i]) || y !== 13'(ey[i]) || in_range !== er[i]) begin
        errors++;
        $display("FAIL corner_idx%0d got (%0d,%0d,%b) want (%0d,%0d,%b)",
                 idx[i], x, y, in_range, ex[i], ey[i], er[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div(CNT_6P25M, 11);
    test_div(0, 6);
    test_div(3, 6);
    test_count_switch();
    test_reset_mid();
    test_coord_corners();
    test_coord_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
